// File: rtl/tlp_frame_receiver.sv
// Receive framing stage: STP/END/EDB delimiting, MSB-first packing into a 128-bit TLP, valid/ready holding register.
// Latency: TLP valid 1 cycle after END; a completion meeting a stalled holding register is dropped. Optional stats: TLP_FRAME_RX_STATS_EN.
module tlp_frame_receiver #(
  parameter int MAX_SYMS = 16,
  parameter int TIMEOUT  = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  input  logic [7:0]   in_symbol,
  input  logic         in_is_k,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_data,
  output logic [4:0]   out_len,
  output logic         nullified,
  output logic         frame_err,
  output logic         drop
`ifdef TLP_FRAME_RX_STATS_EN
  ,
  output logic [15:0]  stat_good,
  output logic [15:0]  stat_null,
  output logic [15:0]  stat_err
`endif
);

  typedef enum logic {IDLE, COLLECT} state_t;

  localparam logic [4:0] MAX_CNT = 5'(MAX_SYMS);
  localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

  state_t        state_q;
  logic [4:0]    sym_cnt_q;
  logic [7:0]    idle_cnt_q;
  logic [127:0]  buf_q;
  logic          out_valid_q;
  logic [127:0]  out_data_q;
  logic [4:0]    out_len_q;
  logic          nullified_q;
  logic          frame_err_q;
  logic          drop_q;

  logic is_stp, is_end, is_edb, held_busy, end_good, good_load;

  assign is_stp    = in_is_k && (in_symbol == 8'hFA);
  assign is_end    = in_is_k && (in_symbol == 8'hFD);
  assign is_edb    = in_is_k && (in_symbol == 8'hFB);
  assign held_busy = out_valid_q && !out_ready;
  assign end_good  = (state_q == COLLECT) && in_valid && is_end && (sym_cnt_q != 5'd0);
  assign good_load = end_good && !held_busy;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      sym_cnt_q   <= 5'd0;
      idle_cnt_q  <= 8'd0;
      buf_q       <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_len_q   <= 5'd0;
      nullified_q <= 1'b0;
      frame_err_q <= 1'b0;
      drop_q      <= 1'b0;
    end else begin
      nullified_q <= 1'b0;
      frame_err_q <= 1'b0;
      drop_q      <= 1'b0;
      if (out_valid_q && out_ready) out_valid_q <= 1'b0;
      case (state_q)
        IDLE: begin
          idle_cnt_q <= 8'd0;
          if (in_valid && is_stp) begin
            state_q   <= COLLECT;
            sym_cnt_q <= 5'd0;
            buf_q     <= '0;
          end
        end
        COLLECT: begin
          if (!in_valid) begin
            if (idle_cnt_q == TO_LAST) begin
              frame_err_q <= 1'b1;
              state_q     <= IDLE;
              idle_cnt_q  <= 8'd0;
            end else begin
              idle_cnt_q <= idle_cnt_q + 8'd1;
            end
          end else begin
            idle_cnt_q <= 8'd0;
            if (!in_is_k) begin
              if (sym_cnt_q == MAX_CNT) begin
                frame_err_q <= 1'b1;
                state_q     <= IDLE;
              end else begin
                for (int i = 0; i < MAX_SYMS; i++)
                  if (sym_cnt_q == 5'(i)) buf_q[127-8*i -: 8] <= in_symbol;
                sym_cnt_q <= sym_cnt_q + 5'd1;
              end
            end else if (is_stp) begin
              // Back-to-back STP restarts the frame rather than leaving it
              frame_err_q <= 1'b1;
              sym_cnt_q   <= 5'd0;
              buf_q       <= '0;
            end else if (is_end) begin
              state_q <= IDLE;
              if (sym_cnt_q == 5'd0) begin
                frame_err_q <= 1'b1;
              end else if (held_busy) begin
                drop_q <= 1'b1;
              end else begin
                out_valid_q <= 1'b1;
                out_data_q  <= buf_q;
                out_len_q   <= sym_cnt_q;
              end
            end else if (is_edb) begin
              nullified_q <= 1'b1;
              state_q     <= IDLE;
            end else begin
              frame_err_q <= 1'b1;
              state_q     <= IDLE;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_len   = out_len_q;
  assign nullified = nullified_q;
  assign frame_err = frame_err_q;
  assign drop      = drop_q;

`ifdef TLP_FRAME_RX_STATS_EN
  logic [15:0] stat_good_q, stat_null_q, stat_err_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_good_q <= 16'd0;
      stat_null_q <= 16'd0;
      stat_err_q  <= 16'd0;
    end else begin
      if (good_load && stat_good_q != 16'hFFFF) stat_good_q <= stat_good_q + 16'd1;
      if (nullified_q && stat_null_q != 16'hFFFF) stat_null_q <= stat_null_q + 16'd1;
      if ((frame_err_q || drop_q) && stat_err_q != 16'hFFFF) stat_err_q <= stat_err_q + 16'd1;
    end
  end

  assign stat_good = stat_good_q;
  assign stat_null = stat_null_q;
  assign stat_err  = stat_err_q;
`endif

endmodule

// File: tb/tb_tlp_frame_receiver.sv
// Bench for tlp_frame_receiver: directed vector table, hand sequences, then random traffic vs a frame-level model.
module tb_tlp_frame_receiver;
  localparam int MAX_SYMS = 16;
  localparam int TIMEOUT  = 8;
  localparam logic Y = 1'b1;
  localparam logic N = 1'b0;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic [7:0]   in_symbol = 8'h00;
  logic         in_is_k = 1'b0;
  logic         out_ready = 1'b0;
  logic         out_valid;
  logic [127:0] out_data;
  logic [4:0]   out_len;
  logic         nullified, frame_err, drop;
`ifdef TLP_FRAME_RX_STATS_EN
  logic [15:0]  stat_good, stat_null, stat_err;
`endif

  always #5 clk = ~clk;

  tlp_frame_receiver #(.MAX_SYMS(MAX_SYMS), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_symbol(in_symbol), .in_is_k(in_is_k),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_len(out_len),
    .nullified(nullified), .frame_err(frame_err), .drop(drop)
`ifdef TLP_FRAME_RX_STATS_EN
    , .stat_good(stat_good), .stat_null(stat_null), .stat_err(stat_err)
`endif
  );

  int vectors = 0;
  int miscompares = 0;

  function automatic void chk(string name, logic [127:0] act, logic [127:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endfunction

  task automatic cyc(input logic v, input logic [7:0] s, input logic k, input logic r);
    @(negedge clk);
    in_valid = v; in_symbol = s; in_is_k = k; out_ready = r;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_pulses(string tag, input logic en, input logic ee, input logic ed);
    chk({tag, "_null"}, 128'(nullified), 128'(en));
    chk({tag, "_err"},  128'(frame_err), 128'(ee));
    chk({tag, "_drop"}, 128'(drop),      128'(ed));
  endtask

  typedef struct {
    logic v; logic [7:0] s; logic k; logic r;
    logic ev; logic [4:0] len; logic [31:0] top;
    logic en; logic ee; logic ed;
  } vec_t;
  vec_t tbl[$];

  function automatic void add(logic v, logic [7:0] s, logic k, logic r, logic ev,
                              logic [4:0] len, logic [31:0] top, logic en, logic ee, logic ed);
    vec_t t;
    t.v = v; t.s = s; t.k = k; t.r = r; t.ev = ev; t.len = len; t.top = top;
    t.en = en; t.ee = ee; t.ed = ed;
    tbl.push_back(t);
  endfunction

  // Frame-level reference: symbols collected in a queue, held TLP as plain variables
  bit           m_in;
  byte unsigned m_frame[$];
  int           m_idle;
  bit           m_v;
  logic [127:0] m_data;
  logic [4:0]   m_len;
  bit           m_n, m_e, m_d;

  task automatic m_reset();
    m_in = 0; m_frame.delete(); m_idle = 0;
    m_v = 0; m_data = '0; m_len = '0; m_n = 0; m_e = 0; m_d = 0;
  endtask

  task automatic m_step(input logic v, input logic [7:0] s, input logic k, input logic r);
    bit complete;
    logic [127:0] nd;
    complete = 0;
    m_n = 0; m_e = 0; m_d = 0;
    if (!m_in) begin
      if (v && k && s == 8'hFA) begin m_in = 1; m_frame.delete(); m_idle = 0; end
    end else if (!v) begin
      m_idle++;
      if (m_idle == TIMEOUT) begin m_e = 1; m_in = 0; m_idle = 0; end
    end else begin
      m_idle = 0;
      if (!k) begin
        if (m_frame.size() < MAX_SYMS) m_frame.push_back(s);
        else begin m_e = 1; m_in = 0; end
      end else if (s == 8'hFD) begin
        if (m_frame.size() == 0) m_e = 1; else complete = 1;
        m_in = 0;
      end else if (s == 8'hFB) begin
        m_n = 1; m_in = 0;
      end else if (s == 8'hFA) begin
        m_e = 1; m_frame.delete();
      end else begin
        m_e = 1; m_in = 0;
      end
    end
    if (complete && (!m_v || r)) begin
      nd = '0;
      for (int i = 0; i < m_frame.size(); i++) nd[127-8*i -: 8] = m_frame[i];
      m_v = 1; m_data = nd; m_len = 5'(m_frame.size());
    end else begin
      if (complete) m_d = 1;
      if (m_v && r) m_v = 0;
    end
  endtask

  initial begin
    int dens;
    logic rv, rk, rr;
    logic [7:0] rs;
    int sel;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid", 128'(out_valid), 128'(0));
    chk("rst_data",  out_data, 128'(0));
    chk("rst_len",   128'(out_len), 128'(0));
    chk_pulses("rst", N, N, N);
    @(negedge clk);
    rst_n = 1'b1;

    // Good 4-symbol frame
    add(Y, 8'hFA, Y, Y, N, 0, 0, N, N, N);
    add(Y, 8'h11, N, Y, N, 0, 0, N, N, N);
    add(Y, 8'h22, N, Y, N, 0, 0, N, N, N);
    add(Y, 8'h33, N, Y, N, 0, 0, N, N, N);
    add(Y, 8'h44, N, Y, N, 0, 0, N, N, N);
    add(Y, 8'hFD, Y, Y, Y, 4, 32'h11223344, N, N, N);
    add(N, 8'h00, N, Y, N, 0, 0, N, N, N);
    // Symbols outside a frame are ignored
    add(Y, 8'hFD, Y, Y, N, 0, 0, N, N, N);
    add(Y, 8'h5A, N, Y, N, 0, 0, N, N, N);
    add(Y, 8'hFB, Y, Y, N, 0, 0, N, N, N);
    // Nullified frame
    add(Y, 8'hFA, Y, Y, N, 0, 0, N, N, N);
    add(Y, 8'hAA, N, Y, N, 0, 0, N, N, N);
    add(Y, 8'hBB, N, Y, N, 0, 0, N, N, N);
    add(Y, 8'hFB, Y, Y, N, 0, 0, Y, N, N);
    add(N, 8'h00, N, Y, N, 0, 0, N, N, N);
    // Backpressure: second frame dropped, first held
    add(Y, 8'hFA, Y, N, N, 0, 0, N, N, N);
    add(Y, 8'h01, N, N, N, 0, 0, N, N, N);
    add(Y, 8'hFD, Y, N, Y, 1, 32'h01000000, N, N, N);
    add(N, 8'h00, N, N, Y, 1, 32'h01000000, N, N, N);
    add(Y, 8'hFA, Y, N, Y, 1, 32'h01000000, N, N, N);
    add(Y, 8'h02, N, N, Y, 1, 32'h01000000, N, N, N);
    add(Y, 8'hFD, Y, N, Y, 1, 32'h01000000, N, N, Y);
    add(N, 8'h00, N, N, Y, 1, 32'h01000000, N, N, N);
    add(N, 8'h00, N, Y, N, 0, 0, N, N, N);
    // Full MAX_SYMS frame is good
    add(Y, 8'hFA, Y, Y, N, 0, 0, N, N, N);
    for (int i = 0; i < MAX_SYMS; i++) add(Y, 8'(i + 1), N, Y, N, 0, 0, N, N, N);
    add(Y, 8'hFD, Y, Y, Y, 16, 32'h01020304, N, N, N);
    add(N, 8'h00, N, Y, N, 0, 0, N, N, N);
    // Overflow on symbol MAX_SYMS+1
    add(Y, 8'hFA, Y, Y, N, 0, 0, N, N, N);
    for (int i = 0; i < MAX_SYMS; i++) add(Y, 8'hC0, N, Y, N, 0, 0, N, N, N);
    add(Y, 8'hC1, N, Y, N, 0, 0, N, Y, N);
    add(N, 8'h00, N, Y, N, 0, 0, N, N, N);
    // Empty frame
    add(Y, 8'hFA, Y, Y, N, 0, 0, N, N, N);
    add(Y, 8'hFD, Y, Y, N, 0, 0, N, Y, N);
    add(N, 8'h00, N, Y, N, 0, 0, N, N, N);
    // Unknown K inside a frame
    add(Y, 8'hFA, Y, Y, N, 0, 0, N, N, N);
    add(Y, 8'h10, N, Y, N, 0, 0, N, N, N);
    add(Y, 8'hBC, Y, Y, N, 0, 0, N, Y, N);
    // STP inside a frame restarts it
    add(Y, 8'hFA, Y, Y, N, 0, 0, N, N, N);
    add(Y, 8'h77, N, Y, N, 0, 0, N, N, N);
    add(Y, 8'hFA, Y, Y, N, 0, 0, N, Y, N);
    add(Y, 8'h88, N, Y, N, 0, 0, N, N, N);
    add(Y, 8'hFD, Y, Y, Y, 1, 32'h88000000, N, N, N);
    add(N, 8'h00, N, Y, N, 0, 0, N, N, N);

    foreach (tbl[i]) begin
      cyc(tbl[i].v, tbl[i].s, tbl[i].k, tbl[i].r);
      chk($sformatf("tbl%0d_valid", i), 128'(out_valid), 128'(tbl[i].ev));
      chk_pulses($sformatf("tbl%0d", i), tbl[i].en, tbl[i].ee, tbl[i].ed);
      if (tbl[i].ev) begin
        chk($sformatf("tbl%0d_len", i), 128'(out_len), 128'(tbl[i].len));
        chk($sformatf("tbl%0d_top", i), 128'(out_data[127:96]), 128'(tbl[i].top));
        if (tbl[i].len <= 5'd4) chk($sformatf("tbl%0d_low", i), 128'(out_data[95:0]), 128'(0));
      end
    end

    // Timeout after TIMEOUT idle cycles, trailing END ignored
    cyc(Y, 8'hFA, Y, Y);
    cyc(Y, 8'h55, N, Y);
    for (int i = 1; i <= TIMEOUT; i++) begin
      cyc(N, 8'h00, N, Y);
      chk($sformatf("to_idle%0d_err", i), 128'(frame_err), 128'(i == TIMEOUT));
    end
    cyc(N, 8'h00, N, Y);
    chk("to_after_err", 128'(frame_err), 128'(0));
    cyc(Y, 8'hFD, Y, Y);
    chk("to_end_valid", 128'(out_valid), 128'(0));
    chk_pulses("to_end", N, N, N);

    // One short of timeout, then a symbol clears the idle count
    cyc(Y, 8'hFA, Y, Y);
    cyc(Y, 8'h12, N, Y);
    repeat (TIMEOUT - 1) cyc(N, 8'h00, N, Y);
    chk("to_edge_err", 128'(frame_err), 128'(0));
    cyc(Y, 8'h34, N, Y);
    repeat (TIMEOUT - 1) cyc(N, 8'h00, N, Y);
    cyc(Y, 8'hFD, Y, Y);
    chk("to_edge_valid", 128'(out_valid), 128'(1));
    chk("to_edge_len", 128'(out_len), 128'(2));
    chk("to_edge_data", out_data, {16'h1234, 112'h0});
    cyc(N, 8'h00, N, Y);

    // Reset while a TLP is held
    cyc(Y, 8'hFA, Y, N);
    cyc(Y, 8'h33, N, N);
    cyc(Y, 8'hFD, Y, N);
    chk("held_valid", 128'(out_valid), 128'(1));
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("held_rst_valid", 128'(out_valid), 128'(0));
    chk("held_rst_data", out_data, 128'(0));
    @(negedge clk);
    rst_n = 1'b1;

    // Reset mid-frame discards the partial frame
    cyc(Y, 8'hFA, Y, Y);
    cyc(Y, 8'h66, N, Y);
    @(negedge clk);
    rst_n = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    cyc(Y, 8'hFD, Y, Y);
    chk("midrst_valid", 128'(out_valid), 128'(0));
    chk_pulses("midrst", N, N, N);
    cyc(N, 8'h00, N, Y);
    chk_pulses("midrst2", N, N, N);
`ifdef TLP_FRAME_RX_STATS_EN
    chk("stat_good0", 128'(stat_good), 128'(0));
    chk("stat_null0", 128'(stat_null), 128'(0));
    chk("stat_err0",  128'(stat_err),  128'(0));
`endif

    // Random traffic against the model
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    m_reset();
    dens = 90;
    for (int c = 0; c < 3000; c++) begin
      if (c % 250 == 0) begin
        sel = int'($urandom_range(0, 2));
        dens = (sel == 0) ? 95 : (sel == 1) ? 60 : 10;
      end
      rv = (int'($urandom_range(0, 99)) < dens);
      sel = int'($urandom_range(0, 9));
      rk = (sel <= 3);
      case (sel)
        0: rs = 8'hFA;
        1: rs = 8'hFD;
        2: rs = 8'hFB;
        3: rs = 8'hBC;
        default: rs = 8'($urandom);
      endcase
      rr = ($urandom_range(0, 3) != 0);
      m_step(rv, rs, rk, rr);
      cyc(rv, rs, rk, rr);
      chk("rnd_valid", 128'(out_valid), 128'(m_v));
      chk("rnd_data", out_data, m_data);
      chk("rnd_len", 128'(out_len), 128'(m_len));
      chk_pulses("rnd", m_n, m_e, m_d);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/tlp_frame_receiver.md
Name: tlp_frame_receiver

Overview:
- Receive-side framing stage that consumes the per-symbol stream produced by the TLP transmitter: valid strobe, 8-bit symbol and a control (K) flag.
- Delimits frames on STP (0xFA) / END (0xFD) / EDB (0xFB) K-symbols.
- Packs the data symbols MSB-first into a 128-bit buffer and presents each completed good TLP on a valid/ready output holding register.
- Reports nullified frames, framing errors and dropped frames as single-cycle pulses.

Parameters:
- MAX_SYMS, 16, maximum data symbols per frame (legal range 1..16; buffer is 8*16 bits).
- TIMEOUT, 8, consecutive cycles without in_valid inside a frame before the frame is aborted (legal range 1..255).

Ports:
- clk  in  1  single clock; all logic posedge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  symbol strobe.
- in_symbol  in  8  symbol value.
- in_is_k  in  1  1 = control symbol, 0 = data symbol.
- out_valid  out  1  completed good TLP held.
- out_ready  in  1  consumer accepts when out_valid & out_ready.
- out_data  out  128  packed TLP: symbol 0 in [127:120], symbol k in [127-8k -: 8], unused bits 0.
- out_len  out  5  number of data symbols (1..MAX_SYMS).
- nullified  out  1  one-cycle pulse: frame ended by EDB.
- frame_err  out  1  one-cycle pulse: framing error.
- drop  out  1  one-cycle pulse: good frame lost because the holding register was full.

Behaviour:
- Reset (async assert, sync release): state IDLE, sym_cnt=0, idle_cnt=0, buffer=0. Outputs: out_valid=0, out_data=0, out_len=0, nullified=0, frame_err=0, drop=0.
- Reset mid-frame discards the partial frame. Reset while out_valid=1 discards the held TLP.
- FSM has two states: IDLE and COLLECT. Only cycles with in_valid=1 are symbol events.
- IDLE:
  - K 0xFA -> COLLECT; sym_cnt=0; buffer cleared.
  - Every other symbol is ignored; no error is raised.
- COLLECT, data symbol:
  - If sym_cnt<MAX_SYMS: store the symbol at slot sym_cnt; sym_cnt+1.
  - If sym_cnt==MAX_SYMS: frame_err; -> IDLE.
- COLLECT, K 0xFD (END):
  - If sym_cnt==0: frame_err; -> IDLE.
  - Otherwise: frame good; -> IDLE; completion.
- COLLECT, K 0xFB (EDB): nullified; frame discarded; -> IDLE. Nullified frames are never delivered.
- COLLECT, K 0xFA: frame_err; current frame discarded; stay in COLLECT with a fresh frame (sym_cnt=0).
- COLLECT, any other K symbol: frame_err; -> IDLE.
- Timeout:
  - idle_cnt counts cycles with in_valid=0 while in COLLECT; it clears on any in_valid=1.
  - When idle_cnt reaches TIMEOUT: frame_err; -> IDLE.
- Pulse timing: nullified, frame_err and drop are registered. Each is high for exactly the one cycle after the triggering event.
- Completion (END accepted in cycle N):
  - If out_valid=0, or out_valid=1 with out_ready=1 in cycle N: load out_data/out_len; out_valid=1 from cycle N+1.
  - If out_valid=1 and out_ready=0 in cycle N: new frame discarded; drop pulses at N+1; held TLP unchanged.
- Accept without a new completion: out_valid clears the cycle after out_valid&out_ready. out_data/out_len hold their last value.
- Held values: out_data and out_len remain stable while out_valid=1 and out_ready=0.
- Simultaneous events: a symbol event and a timeout cannot coincide, because in_valid=1 clears idle_cnt.

Optional Feature:
- Macro TLP_FRAME_RX_STATS_EN.
- Defined: adds three 16-bit saturating output ports, stat_good, stat_null and stat_err.
  - stat_good increments on each loaded good TLP.
  - stat_null increments on each nullified pulse.
  - stat_err increments on each frame_err or drop pulse.
  - All three reset to 0 and hold at 0xFFFF.
- Undefined: the ports and counters do not exist; all other behaviour is identical.

Test Plan:
- Good frame, out_ready=1: K FA, data 11 22 33 44, K FD -> out_valid one cycle after FD; out_len=4; out_data[127:96]=0x11223344; lower bits 0; no pulses.
- Nullified frame: K FA, data AA BB, K FB -> nullified pulse one cycle after FB; out_valid stays 0.
- Backpressure: out_ready=0; frame A (data 01), then frame B (data 02) -> drop pulse after B's FD; out_data[127:120]=0x01; raising out_ready clears out_valid next cycle.
- Overflow and empty frame: K FA followed by 17 data symbols -> frame_err after the 17th; K FA, K FD -> frame_err; out_valid stays 0 in both cases.
- Timeout: K FA, data 55, then in_valid=0 for 8 cycles -> frame_err one cycle after the 8th idle cycle; a later K FD (in IDLE) is ignored.
- Reset mid-frame: K FA, data 66, rst_n low for 1 cycle, then K FD -> no output and no pulses; with TLP_FRAME_RX_STATS_EN, all stats read 0.
